// File: rtl/seven_seg_scanner_if.sv
// ============================================================================
// Module      : seven_seg_scanner_if
// Description : Display-data and multiplexed-output bundle for the scanner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface seven_seg_scanner_if;
    logic [20:0] display_data;
    logic        load;
    logic        blink_en;
    logic [6:0]  seg;
    logic [2:0]  an;
    logic        frame_done;

    modport master (
        output display_data, load, blink_en,
        input  seg, an, frame_done
    );

    modport slave (
        input  display_data, load, blink_en,
        output seg, an, frame_done
    );
endinterface

`default_nettype wire

// File: rtl/seven_seg_scanner.sv
// ============================================================================
// Module      : seven_seg_scanner
// Description : Three-digit 7-segment scanner with tear-free frame-boundary
//               updates, anti-ghosting blank time and whole-display blink.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module seven_seg_scanner #(
    parameter int unsigned SCAN_DIV       = 50,
    parameter int unsigned BLANK_CYCLES   = 2,
    parameter int unsigned BLINK_DIV      = 8,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  wire logic            clk,
    input  wire logic            rst,
    seven_seg_scanner_if.slave   disp
);

    localparam int unsigned SLOT_W  = $clog2(SCAN_DIV);
    localparam int unsigned FRAME_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SLOT_W-1:0]  c_slot_last  = SLOT_W'(SCAN_DIV - 1);
    localparam logic [SLOT_W-1:0]  c_blank_end  = SLOT_W'(BLANK_CYCLES);
    localparam logic [FRAME_W-1:0] c_frame_last = FRAME_W'(BLINK_DIV - 1);
    localparam logic [6:0]         c_unlit      = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    logic [SLOT_W-1:0]  r_slot_cnt;
    logic [1:0]         r_digit_idx;
    logic [FRAME_W-1:0] r_frame_cnt;
    logic               r_blink_phase;
    logic               r_pending;
    logic [20:0]        r_shadow;
    logic [20:0]        r_active;
    logic               r_boundary_d;
    logic [6:0]         r_seg;
    logic [2:0]         r_an;
    logic               r_frame_done;

    logic               w_slot_last;
    logic               w_boundary;
    logic               w_blank;
    logic [6:0]         w_digit_pat;
    logic [2:0]         w_an_onehot;

    assign w_slot_last = (r_slot_cnt == c_slot_last);
    assign w_boundary  = w_slot_last && (r_digit_idx == 2'd2);
    assign w_blank     = (r_slot_cnt < c_blank_end) || (disp.blink_en && r_blink_phase);

    always_comb begin
        w_digit_pat = r_active[20:14];
        w_an_onehot = 3'b100;
        case (r_digit_idx)
            2'd0: begin
                w_digit_pat = r_active[6:0];
                w_an_onehot = 3'b001;
            end
            2'd1: begin
                w_digit_pat = r_active[13:7];
                w_an_onehot = 3'b010;
            end
            default: begin
                w_digit_pat = r_active[20:14];
                w_an_onehot = 3'b100;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot_cnt    <= '0;
            r_digit_idx   <= 2'd0;
            r_frame_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else begin
            if (w_slot_last) begin
                r_slot_cnt  <= '0;
                r_digit_idx <= (r_digit_idx == 2'd2) ? 2'd0 : r_digit_idx + 2'd1;
            end else begin
                r_slot_cnt  <= r_slot_cnt + 1'b1;
            end
            if (w_boundary) begin
                if (r_frame_cnt == c_frame_last) begin
                    r_frame_cnt   <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_frame_cnt   <= r_frame_cnt + 1'b1;
                end
            end
        end
    end

    // A load landing on the boundary bypasses the shadow so it shows next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow  <= '0;
            r_active  <= '0;
            r_pending <= 1'b0;
        end else begin
            if (disp.load) begin
                r_shadow <= disp.display_data;
            end
            if (w_boundary) begin
                r_pending <= 1'b0;
                if (disp.load) begin
                    r_active <= disp.display_data;
                end else if (r_pending) begin
                    r_active <= r_shadow;
                end
            end else if (disp.load) begin
                r_pending <= 1'b1;
            end
        end
    end

    // frame_done trails the boundary by two stages so it follows the frame's last lit output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg        <= c_unlit;
            r_an         <= 3'b000;
            r_boundary_d <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_boundary_d <= w_boundary;
            r_frame_done <= r_boundary_d;
            if (w_blank) begin
                r_an  <= 3'b000;
                r_seg <= c_unlit;
            end else begin
                r_an  <= w_an_onehot;
                r_seg <= w_digit_pat ^ {7{SEG_ACTIVE_LOW}};
            end
        end
    end

    assign disp.seg        = r_seg;
    assign disp.an         = r_an;
    assign disp.frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_scanner.sv
// ============================================================================
// Module      : tb_seven_seg_scanner
// Description : Scoreboard bench for seven_seg_scanner, both segment polarities.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_seven_seg_scanner;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seven_seg_scanner_if if_lo ();
    seven_seg_scanner_if if_hi ();

    assign if_hi.display_data = if_lo.display_data;
    assign if_hi.load         = if_lo.load;
    assign if_hi.blink_en     = if_lo.blink_en;

    seven_seg_scanner #(.SEG_ACTIVE_LOW(1'b1)) dut_lo (
        .clk  (clk),
        .rst  (rst),
        .disp (if_lo.slave)
    );

    seven_seg_scanner #(.SEG_ACTIVE_LOW(1'b0)) dut_hi (
        .clk  (clk),
        .rst  (rst),
        .disp (if_hi.slave)
    );

    typedef struct {
        logic [2:0] an;
        logic [6:0] pat;
        int         start;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   edge_cnt = 0;
    bit   mon_en   = 1'b0;

    localparam logic [20:0] W_BASIC = 21'h16C33F;
    localparam logic [20:0] W_BND   = 21'h0E7E77;
    localparam logic [20:0] W_A     = 21'h17BCF1;
    localparam logic [20:0] W_B     = 21'h01ADCF;

    always @(posedge clk or posedge rst) begin
        if (rst) edge_cnt <= 0;
        else     edge_cnt <= edge_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    task automatic push_frame(input logic [20:0] word);
        exp_t e;
        e.an = 3'b001; e.pat = word[6:0];   e.start = 3;   sb_q.push_back(e);
        e.an = 3'b010; e.pat = word[13:7];  e.start = 53;  sb_q.push_back(e);
        e.an = 3'b100; e.pat = word[20:14]; e.start = 103; sb_q.push_back(e);
    endtask

    // Monitor: pops one expectation per lit digit slot and checks timing/values.
    exp_t cur;
    bit   in_run  = 1'b0;
    int   run_len = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                in_run = 1'b0;
                continue;
            end
            if (if_lo.an != 3'b000) begin
                if (!in_run) begin
                    if (sb_q.size() == 0) begin
                        check("sb_unexpected_slot", {29'd0, if_lo.an}, 32'd0);
                    end else begin
                        cur     = sb_q.pop_front();
                        in_run  = 1'b1;
                        run_len = 0;
                        check("slot_start_pos", edge_cnt % 150, cur.start);
                    end
                end
                if (in_run) begin
                    check("an_lo",  {29'd0, if_lo.an},  {29'd0, cur.an});
                    check("seg_lo", {25'd0, if_lo.seg}, {25'd0, cur.pat ^ 7'h7F});
                    check("an_hi",  {29'd0, if_hi.an},  {29'd0, cur.an});
                    check("seg_hi", {25'd0, if_hi.seg}, {25'd0, cur.pat});
                    run_len++;
                end
            end else begin
                if (in_run) begin
                    check("lit_len", run_len, 48);
                    in_run = 1'b0;
                end
                check("blank_seg_lo", {25'd0, if_lo.seg}, 32'h7F);
                check("blank_an_hi",  {29'd0, if_hi.an},  32'd0);
                check("blank_seg_hi", {25'd0, if_hi.seg}, 32'd0);
            end
            check("frame_done_lo", {31'd0, if_lo.frame_done},
                  {31'd0, (edge_cnt >= 151) && (edge_cnt % 150 == 1)});
            check("frame_done_hi", {31'd0, if_hi.frame_done},
                  {31'd0, (edge_cnt >= 151) && (edge_cnt % 150 == 1)});
        end
    end

    initial begin
        logic [20:0] shown;
        if_lo.display_data = '0;
        if_lo.load         = 1'b0;
        if_lo.blink_en     = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_an",     {29'd0, if_lo.an},         32'd0);
        check("rst_seg_lo", {25'd0, if_lo.seg},        32'h7F);
        check("rst_seg_hi", {25'd0, if_hi.seg},        32'd0);
        check("rst_fd",     {31'd0, if_lo.frame_done}, 32'd0);
        rst = 1'b0;

        // Mid-digit1 of the third frame, then an asynchronous reset.
        repeat (370) @(negedge clk);
        check("pre_rst_an", {29'd0, if_lo.an}, 32'h2);
        #2 rst = 1'b1;
        #1;
        check("async_rst_an",     {29'd0, if_lo.an},  32'd0);
        check("async_rst_seg_lo", {25'd0, if_lo.seg}, 32'h7F);
        check("async_rst_seg_hi", {25'd0, if_hi.seg}, 32'd0);
        repeat (3) @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;

        for (int f = 0; f < 25; f++) begin
            case (f)
                0:       shown = 21'h0;
                1:       shown = W_BASIC;
                2:       shown = 21'h0;
                3:       shown = W_BND;
                default: shown = W_B;
            endcase
            if_lo.blink_en = (f >= 5);
            if (!((f >= 5) && (((f / 8) % 2) == 1)))
                push_frame(shown);
            for (int p = 0; p < 150; p++) begin
                if_lo.load = 1'b0;
                if      (f == 0 && p == 10)  begin if_lo.load = 1'b1; if_lo.display_data = W_BASIC; end
                else if (f == 1 && p == 70)  begin if_lo.load = 1'b1; if_lo.display_data = 21'h0;   end
                else if (f == 2 && p == 149) begin if_lo.load = 1'b1; if_lo.display_data = W_BND;   end
                else if (f == 3 && p == 20)  begin if_lo.load = 1'b1; if_lo.display_data = W_A;     end
                else if (f == 3 && p == 120) begin if_lo.load = 1'b1; if_lo.display_data = W_B;     end
                @(posedge clk);
                @(negedge clk);
            end
        end
        if_lo.load = 1'b0;
        repeat (4) @(negedge clk);
        check("sb_drained", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
